// File: rtl/avmm_copy_pkg.sv
// rtl/avmm_copy_pkg.sv - shared types and constants for the Avalon-MM word copy master
package avmm_copy_pkg;

    // Copy sequencer states: one read, one wait for data, one write per word
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        RWAIT = 3'd2,
        WR    = 3'd3,
        FIN   = 3'd4
    } state_e;

    // Pointers advance by one 32-bit word per copied word
    localparam int WORD_BYTES = 4;

    // Every transfer is a full word
    localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/avmm_copy_master.sv
// rtl/avmm_copy_master.sv - Avalon-MM master copying LEN words from SRC to DST (optional AVMM_COPY_CHECKSUM_EN)
module avmm_copy_master
    import avmm_copy_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    output logic              m_write,
    output logic [3:0]        m_byteenable,
    output logic [31:0]       m_writedata,
    input  logic [31:0]       m_readdata,
    input  logic              m_readdatavalid,
    input  logic              m_waitrequest
`ifdef AVMM_COPY_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    // Word alignment: the two low address bits are always dropped
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORD_BYTES - 1);
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(WORD_BYTES);

    state_e            state;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [LEN_W-1:0]  cnt;
    logic [31:0]       data_buf;
    logic [3:0]        be_q;

    // Copy sequencer: latch job on start, then read/wait/write each word until the count runs out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            src_ptr  <= '0;
            dst_ptr  <= '0;
            cnt      <= '0;
            data_buf <= '0;
            be_q     <= '0;
        end else begin
            // Byte enables read zero only while in reset; full word otherwise
            be_q <= BE_ALL;
            case (state)
                IDLE: begin
                    if (start) begin
                        src_ptr <= src_addr & ALIGN_MASK;
                        dst_ptr <= dst_addr & ALIGN_MASK;
                        cnt     <= len;
                        state   <= (len == '0) ? FIN : RD;
                    end
                end
                RD: begin
                    if (!m_waitrequest) begin
                        state <= RWAIT;
                    end
                end
                RWAIT: begin
                    // Data arriving in any other state is not ours and is dropped
                    if (m_readdatavalid) begin
                        data_buf <= m_readdata;
                        state    <= WR;
                    end
                end
                WR: begin
                    if (!m_waitrequest) begin
                        src_ptr <= src_ptr + STEP;
                        dst_ptr <= dst_ptr + STEP;
                        cnt     <= cnt - LEN_W'(1);
                        state   <= (cnt == LEN_W'(1)) ? FIN : RD;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef AVMM_COPY_CHECKSUM_EN
    // Running sum of every captured read word; restarts on each accepted job
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum <= '0;
        end else if (state == IDLE && start) begin
            checksum <= '0;
        end else if (state == RWAIT && m_readdatavalid) begin
            checksum <= checksum + m_readdata;
        end
    end
`endif

    // Bus and status outputs decoded purely from registered state and pointers
    always_comb begin
        busy         = (state != IDLE);
        done         = (state == FIN);
        m_read       = (state == RD);
        m_write      = (state == WR);
        m_byteenable = be_q;
        m_address    = '0;
        m_writedata  = '0;
        if (state == RD) begin
            m_address = src_ptr;
        end else if (state == WR) begin
            m_address   = dst_ptr;
            m_writedata = data_buf;
        end
    end

endmodule
